// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects the write-back value, commits it to the 32x32
// architectural register file, and serves the two ID read ports with write-first bypass.
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_07FC,
    parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] WB_inA,
    input  logic [31:0] WB_inB,
    input  logic [31:0] WB_PC,
    input  logic [1:0]  WB_MemtoReg,
    input  logic [1:0]  WB_RegDst,
    input  logic [4:0]  WB_WrReg,
    input  logic        WB_RegWr,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    output logic [31:0] ID_rdataA,
    output logic [31:0] ID_rdataB,
    output logic [31:0] WB_wdata,
    output logic [4:0]  WB_wreg,
    output logic        WB_wen,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] wr_cnt
);

    logic [31:0] regs_reg [32];
    logic [31:0] wr_cnt_reg;
    logic [31:0] wdata_next;
    logic [4:0]  wreg_next;
    logic        wen_next;

    // Code 11 is unused by the decoder; it falls back to the ALU result.
    always_comb begin
        wdata_next = WB_inA;
        case (WB_MemtoReg)
            2'b01:   wdata_next = WB_inB;
            2'b10:   wdata_next = WB_PC;
            default: wdata_next = WB_inA;
        endcase
    end

    assign wreg_next = (WB_RegDst == 2'b10) ? 5'd31 : WB_WrReg;
    // RegWr=0 forces the enable low even if the selects are unknown.
    assign wen_next  = WB_RegWr & (wreg_next != 5'd0);

    assign WB_wdata = wdata_next;
    assign WB_wreg  = wreg_next;
    assign WB_wen   = wen_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_reg[i] <= (i == 29) ? SP_INIT : (i == 28) ? GP_INIT : 32'd0;
            end
            wr_cnt_reg <= 32'd0;
        end else if (wen_next) begin
            regs_reg[wreg_next] <= wdata_next;
            wr_cnt_reg          <= wr_cnt_reg + 32'd1;
        end
    end

    always_comb begin
        ID_rdataA = regs_reg[ID_rs];
        if (ID_rs == 5'd0) begin
            ID_rdataA = 32'd0;
        end else if (wen_next && (ID_rs == wreg_next)) begin
            ID_rdataA = wdata_next;
        end
    end

    always_comb begin
        ID_rdataB = regs_reg[ID_rt];
        if (ID_rt == 5'd0) begin
            ID_rdataB = 32'd0;
        end else if (wen_next && (ID_rt == wreg_next)) begin
            ID_rdataB = wdata_next;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs_reg[dbg_addr];
    assign wr_cnt   = wr_cnt_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset image, write-data/destination
// selects, bypass, $0 discard, reset priority and counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] WB_inA, WB_inB, WB_PC;
    logic [1:0]  WB_MemtoReg, WB_RegDst;
    logic [4:0]  WB_WrReg;
    logic        WB_RegWr;
    logic [4:0]  ID_rs, ID_rt;
    logic [31:0] ID_rdataA, ID_rdataB, WB_wdata;
    logic [4:0]  WB_wreg;
    logic        WB_wen;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data, wr_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .WB_inA(WB_inA), .WB_inB(WB_inB), .WB_PC(WB_PC),
        .WB_MemtoReg(WB_MemtoReg), .WB_RegDst(WB_RegDst),
        .WB_WrReg(WB_WrReg), .WB_RegWr(WB_RegWr),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_rdataA(ID_rdataA), .ID_rdataB(ID_rdataB),
        .WB_wdata(WB_wdata), .WB_wreg(WB_wreg), .WB_wen(WB_wen),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_cnt(wr_cnt)
    );

    // Stimulus helpers: present a write-back transaction, and advance one edge.
    task automatic drive_wb(input logic wr, input logic [1:0] m2r, input logic [1:0] dst,
                            input logic [4:0] wreg, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] pc);
        WB_RegWr = wr; WB_MemtoReg = m2r; WB_RegDst = dst; WB_WrReg = wreg;
        WB_inA = a; WB_inB = b; WB_PC = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        WB_RegWr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset = 1'b1;
        drive_wb(1'b0, 2'b00, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0);
        ID_rs = 5'd0; ID_rt = 5'd0; dbg_addr = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            dbg_addr = r[4:0];
            #1;
            exp = (r == 29) ? 32'h0000_07FC : (r == 28) ? 32'h0000_1800 : 32'd0;
            checks++;
            if (dbg_data !== exp) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", r, dbg_data, exp);
            end
        end
        checks++;
        if (wr_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_wr_cnt: got %h expected 0", wr_cnt);
        end
        $display("reset: register image and wr_cnt checked");
    endtask

    task automatic test_alu_bypass();
        @(negedge clk);
        drive_wb(1'b1, 2'b00, 2'b01, 5'd8, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0);
        ID_rs = 5'd8; ID_rt = 5'd0;
        #1;
        checks++;
        if (ID_rdataA !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_bypassA: got %h expected deadbeef", ID_rdataA);
        end
        checks++;
        if (WB_wen !== 1'b1 || WB_wreg !== 5'd8) begin
            errors++; $display("FAIL alu_wen_wreg: got %b/%0d expected 1/8", WB_wen, WB_wreg);
        end
        checks++;
        if (ID_rdataB !== 32'd0) begin
            errors++; $display("FAIL alu_rt0: got %h expected 0", ID_rdataB);
        end
        tick(); exp_cnt++;
        dbg_addr = 5'd8; #1;
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_commit: got %h expected deadbeef", dbg_data);
        end
        checks++;
        if (wr_cnt !== exp_cnt) begin
            errors++; $display("FAIL alu_wr_cnt: got %0d expected %0d", wr_cnt, exp_cnt);
        end
        $display("alu write: $8 <= deadbeef, wr_cnt=%0d", wr_cnt);
    endtask

    task automatic test_load_link();
        @(negedge clk);
        drive_wb(1'b1, 2'b01, 2'b00, 5'd9, 32'h1111_1111, 32'h1234_5678, 32'h0);
        ID_rt = 5'd9;
        #1;
        checks++;
        if (ID_rdataB !== 32'h1234_5678) begin
            errors++; $display("FAIL load_bypassB: got %h expected 12345678", ID_rdataB);
        end
        tick(); exp_cnt++;
        dbg_addr = 5'd9; #1;
        checks++;
        if (dbg_data !== 32'h1234_5678) begin
            errors++; $display("FAIL load_commit: got %h expected 12345678", dbg_data);
        end
        $display("load: $9 <= %h", dbg_data);
        @(negedge clk);
        drive_wb(1'b1, 2'b10, 2'b10, 5'd5, 32'h2222_2222, 32'h3333_3333, 32'h0040_0010);
        #1;
        checks++;
        if (WB_wreg !== 5'd31 || WB_wdata !== 32'h0040_0010) begin
            errors++; $display("FAIL link_select: got %0d/%h expected 31/00400010", WB_wreg, WB_wdata);
        end
        tick(); exp_cnt++;
        dbg_addr = 5'd31; #1;
        checks++;
        if (dbg_data !== 32'h0040_0010) begin
            errors++; $display("FAIL link_commit31: got %h expected 00400010", dbg_data);
        end
        dbg_addr = 5'd5; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++; $display("FAIL link_r5_untouched: got %h expected 0", dbg_data);
        end
        $display("link: $31 <= 00400010, $5 unchanged");
    endtask

    task automatic test_zero_discard();
        @(negedge clk);
        drive_wb(1'b1, 2'b00, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        ID_rs = 5'd0;
        #1;
        checks++;
        if (WB_wen !== 1'b0) begin
            errors++; $display("FAIL zero_wen: got %b expected 0", WB_wen);
        end
        checks++;
        if (ID_rdataA !== 32'd0) begin
            errors++; $display("FAIL zero_readA: got %h expected 0", ID_rdataA);
        end
        tick();
        dbg_addr = 5'd0; #1;
        checks++;
        if (dbg_data !== 32'd0 || wr_cnt !== exp_cnt) begin
            errors++; $display("FAIL zero_commit: got %h/cnt %0d expected 0/cnt %0d", dbg_data, wr_cnt, exp_cnt);
        end
        $display("zero discard: wr_cnt=%0d", wr_cnt);
    endtask

    task automatic test_dual_bypass();
        @(negedge clk);
        drive_wb(1'b1, 2'b11, 2'b01, 5'd12, 32'h0BAD_F00D, 32'h1111_1111, 32'h2222_2222);
        ID_rs = 5'd12; ID_rt = 5'd12;
        #1;
        checks++;
        if (ID_rdataA !== 32'h0BAD_F00D || ID_rdataB !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL dual_bypass: got %h/%h expected 0badf00d", ID_rdataA, ID_rdataB);
        end
        ID_rt = 5'd8; #1;
        checks++;
        if (ID_rdataB !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL dual_stored_read: got %h expected deadbeef", ID_rdataB);
        end
        tick(); exp_cnt++;
        $display("dual bypass: $12 <= 0badf00d via select 11");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_wb(1'b1, 2'b00, 2'b00, 5'd1, 32'h0000_1111, 32'h0, 32'h0);
        @(posedge clk); exp_cnt++;
        @(negedge clk);
        drive_wb(1'b1, 2'b01, 2'b00, 5'd2, 32'h0, 32'h0000_2222, 32'h0);
        ID_rs = 5'd1; ID_rt = 5'd2;
        #1;
        checks++;
        if (ID_rdataA !== 32'h0000_1111 || ID_rdataB !== 32'h0000_2222) begin
            errors++; $display("FAIL b2b_reads: got %h/%h expected 00001111/00002222", ID_rdataA, ID_rdataB);
        end
        tick(); exp_cnt++;
        checks++;
        if (wr_cnt !== exp_cnt) begin
            errors++; $display("FAIL b2b_wr_cnt: got %0d expected %0d", wr_cnt, exp_cnt);
        end
        $display("back-to-back: $1,$2 written, wr_cnt=%0d", wr_cnt);
    endtask

    task automatic test_x_safety();
        @(negedge clk);
        drive_wb(1'b0, 2'bxx, 2'bxx, 5'd8, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (WB_wen !== 1'b0) begin
            errors++; $display("FAIL xsafe_wen: got %b expected 0", WB_wen);
        end
        tick();
        dbg_addr = 5'd8; #1;
        checks++;
        if (dbg_data !== 32'hDEAD_BEEF || wr_cnt !== exp_cnt) begin
            errors++; $display("FAIL xsafe_state: got %h/cnt %0d expected deadbeef/cnt %0d", dbg_data, wr_cnt, exp_cnt);
        end
        $display("x-safety: state unchanged with RegWr=0");
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        reset = 1'b1;
        drive_wb(1'b1, 2'b00, 2'b00, 5'd10, 32'hAAAA_AAAA, 32'h0, 32'h0);
        #1;
        checks++;
        if (WB_wen !== 1'b1 || WB_wdata !== 32'hAAAA_AAAA) begin
            errors++; $display("FAIL rst_comb_outputs: got %b/%h expected 1/aaaaaaaa", WB_wen, WB_wdata);
        end
        @(posedge clk); #1;
        exp_cnt = 32'd0;
        dbg_addr = 5'd10; #1;
        checks++;
        if (dbg_data !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_drop_write: got %h/cnt %0d expected 0/cnt 0", dbg_data, wr_cnt);
        end
        dbg_addr = 5'd8; #1;
        checks++;
        if (dbg_data !== 32'd0) begin
            errors++; $display("FAIL rst_clear_r8: got %h expected 0", dbg_data);
        end
        @(negedge clk);
        drive_wb(1'b1, 2'b00, 2'b00, 5'd29, 32'h1234_5678, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0; WB_RegWr = 1'b0;
        dbg_addr = 5'd29; #1;
        checks++;
        if (dbg_data !== 32'h0000_07FC) begin
            errors++; $display("FAIL rst_sp: got %h expected 000007fc", dbg_data);
        end
        dbg_addr = 5'd28; #1;
        checks++;
        if (dbg_data !== 32'h0000_1800) begin
            errors++; $display("FAIL rst_gp: got %h expected 00001800", dbg_data);
        end
        $display("reset mid-write: writes dropped, $29=%h", 32'h0000_07FC);
    endtask

    task automatic test_counter_wrap();
        @(negedge clk);
        force dut.wr_cnt_reg = 32'hFFFF_FFFF;
        #1;
        release dut.wr_cnt_reg;
        #1;
        checks++;
        if (wr_cnt !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_preload: got %h expected ffffffff", wr_cnt);
        end
        drive_wb(1'b1, 2'b00, 2'b00, 5'd3, 32'h0000_0001, 32'h0, 32'h0);
        tick();
        checks++;
        if (wr_cnt !== 32'd0) begin
            errors++; $display("FAIL wrap_to_zero: got %h expected 0", wr_cnt);
        end
        dbg_addr = 5'd3; #1;
        checks++;
        if (dbg_data !== 32'd1) begin
            errors++; $display("FAIL wrap_commit: got %h expected 1", dbg_data);
        end
        $display("counter wrap: wr_cnt=%h", wr_cnt);
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_load_link();
        test_zero_discard();
        test_dual_bypass();
        test_back_to_back();
        test_x_safety();
        test_reset_mid_write();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs and selects the write-back value. It commits that value to a 32x32 register file and serves the two ID-stage read ports with a write-first bypass. It also exports the resolved write-back triple (value, register, enable) for the EX forwarding unit, plus a committed-write counter for debug.

Parameters:
SP_INIT, 32'h0000_07FC, reset value of $29 ($sp)
GP_INIT, 32'h0000_1800, reset value of $28 ($gp)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
WB_inA  in  32  ALU result from MEM/WB
WB_inB  in  32  memory read data from MEM/WB
WB_PC  in  32  PC+4 of the instruction in WB, used as link value
WB_MemtoReg  in  2  write-data select
WB_RegDst  in  2  destination select
WB_WrReg  in  5  destination register number resolved upstream
WB_RegWr  in  1  register write request
ID_rs  in  5  read address A
ID_rt  in  5  read address B
ID_rdataA  out  32  read data A
ID_rdataB  out  32  read data B
WB_wdata  out  32  selected write-back value, combinational
WB_wreg  out  5  effective destination register, combinational
WB_wen  out  1  effective write enable, combinational
dbg_addr  in  5  debug read address
dbg_data  out  32  debug read data, raw array with no bypass
wr_cnt  out  32  count of committed register writes

Behaviour:
- Reset handling (clk, reset): synchronous, active-high. On a clk edge with reset=1:
  - all registers are cleared to 0, except $29=SP_INIT and $28=GP_INIT;
  - wr_cnt is cleared to 0;
  - any write presented in that cycle is dropped, because reset has priority.
- Write data select (WB_MemtoReg): 00 -> WB_inA; 01 -> WB_inB; 10 -> WB_PC; 11 -> WB_inA.
- Destination select (WB_RegDst): 10 -> 5'd31 for jal/jalr link; any other value -> WB_WrReg.
- Effective enable: WB_wen = WB_RegWr & (WB_wreg != 0). Writes to $0 are silently discarded.
- Commit: at a posedge with reset=0 and WB_wen=1, the register file entry at WB_wreg takes WB_wdata. Write latency is 1 edge.
- $0 always reads 0 on every port, including dbg_data.
- Read ports are combinational:
  - ID_rdataA = 0 if ID_rs==0;
  - else WB_wdata if WB_wen and ID_rs==WB_wreg (write-first bypass, same cycle);
  - else the stored register.
  - ID_rdataB behaves identically using ID_rt. Both ports may hit the bypass simultaneously.
- Outputs while reset is held: ID_rdataA/B, WB_wdata, WB_wreg and WB_wen stay combinational. The register file reflects reset values starting from the edge after reset is first sampled.
- wr_cnt: increments by 1 on each edge with WB_wen=1 and reset=0. It wraps from 32'hFFFF_FFFF to 0 with no saturation.
- X-safety: with WB_RegWr=0, select inputs of any value must not alter state.

Test Plan:
- Reset: hold reset 2 cycles, read all 32 via dbg_addr -> $28=32'h1800, $29=32'h7FC, others 0; wr_cnt=0.
- ALU write plus bypass: WB_RegWr=1, MemtoReg=00, RegDst=01, WrReg=8, inA=32'hDEADBEEF, ID_rs=8 in the same cycle -> ID_rdataA=DEADBEEF before the edge; dbg_data(8)=DEADBEEF after the edge; wr_cnt=1.
- Load and link: MemtoReg=01, inB=32'h12345678, WrReg=9 -> $9=12345678. Then MemtoReg=10, RegDst=10, WrReg=5, WB_PC=32'h0040_0010 -> $31=00400010 and $5 unchanged.
- $0 discard: RegWr=1, WrReg=0, inA=32'hFFFF_FFFF -> WB_wen=0, ID_rdataA(rs=0)=0, wr_cnt unchanged.
- Reset mid-write: reset=1 together with a write of 32'hAAAA_AAAA to $10 -> after the edge $10=0 and wr_cnt=0. With reset=1 and a write to $29, $29=7FC.
- Counter wrap: force 2^32-1 writes (or preload via hierarchical force), apply one more write -> wr_cnt=0.
